// File: rtl/mem_array_arbiter.sv
// Two-requester round-robin arbiter in front of a DEPTH x DATA_W register
// array, with a clear sequencer that zeroes the array and a wrapping count
// of granted accesses.
module mem_array_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic [7:0]        acc_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic              last_gnt_b;
  logic [DATA_W-1:0] mem [DEPTH];

  assign busy = (state == CLEAR);

  // Grant: only in IDLE with no clear request; a tie goes to the requester
  // that was not granted last.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state == IDLE && !clr_start) begin
      if (a_req && (!b_req || last_gnt_b)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  // Array storage: clear sweep writes, otherwise the granted write.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (a_gnt && a_we) begin
      mem[a_addr] <= a_wdata;
    end else if (b_gnt && b_we) begin
      mem[b_addr] <= b_wdata;
    end
  end

  // Clear sequencer FSM and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_idx  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-robin history and granted-access counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_b <= 1'b1;
      acc_cnt    <= '0;
    end else if (a_gnt || b_gnt) begin
      last_gnt_b <= b_gnt;
      acc_cnt    <= acc_cnt + 8'd1;
    end
  end

  // Read ports: one-cycle rvalid pulse, rdata held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= mem[a_addr];
      if (b_gnt && !b_we) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: tb/tb_mem_array_arbiter.sv
// Randomized and directed bench for mem_array_arbiter against a behavioural
// model of the arbitration, array and clear rules.
module tb_mem_array_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we, clr_start;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, busy, clr_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [7:0]    acc_cnt;

  always #5 clk = ~clk;

  mem_array_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done), .acc_cnt(acc_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            busy_left;   // clear writes still to perform; 0 = idle
  bit            last_b;
  int            cnt;
  bit            e_arv, e_brv, e_done;
  logic [DW-1:0] e_ard, e_brd;
  bit            e_ard_k, e_brd_k;
  bit            p_a, p_b;
  bit            g_a, g_b, g_busy;
  int            wa, wb;

  task automatic model_reset();
    busy_left = 0; last_b = 1'b1; cnt = 0;
    e_arv = 0; e_brv = 0; e_done = 0;
    e_ard = '0; e_brd = '0; e_ard_k = 1; e_brd_k = 1;
    wa = 0; wb = 0;
  endtask

  task automatic predict();
    p_a = 0; p_b = 0;
    if (busy_left == 0 && !clr_start) begin
      if (a_req && b_req) begin
        if (last_b) p_a = 1; else p_b = 1;
      end else if (a_req) p_a = 1;
      else if (b_req) p_b = 1;
    end
  endtask

  task automatic model_update();
    bit dn;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dn = (busy_left == 1);
    e_arv = 0; e_brv = 0;
    if (busy_left > 0) begin
      m_mem[DEPTH - busy_left] = '0;
      m_known[DEPTH - busy_left] = 1;
      busy_left--;
    end else if (clr_start) begin
      busy_left = DEPTH;
    end else if (p_a) begin
      last_b = 0; cnt = (cnt + 1) % 256;
      if (a_we) begin m_mem[a_addr] = a_wdata; m_known[a_addr] = 1; end
      else begin e_arv = 1; e_ard = m_mem[a_addr]; e_ard_k = m_known[a_addr]; end
    end else if (p_b) begin
      last_b = 1; cnt = (cnt + 1) % 256;
      if (b_we) begin m_mem[b_addr] = b_wdata; m_known[b_addr] = 1; end
      else begin e_brv = 1; e_brd = m_mem[b_addr]; e_brd_k = m_known[b_addr]; end
    end
    e_done = dn;
  endtask

  // One clock: called just after a falling edge with inputs already applied.
  task automatic cycle();
    #2;
    predict();
    g_a = a_gnt; g_b = b_gnt; g_busy = busy;
    check("a_gnt", 32'(a_gnt), 32'(p_a));
    check("b_gnt", 32'(b_gnt), 32'(p_b));
    check("gnt_onehot", 32'(a_gnt & b_gnt), 32'd0);
    check("busy", 32'(busy), 32'(busy_left > 0));
    check("clr_done", 32'(clr_done), 32'(e_done));
    check("acc_cnt", 32'(acc_cnt), 32'(cnt));
    check("a_rvalid", 32'(a_rvalid), 32'(e_arv));
    check("b_rvalid", 32'(b_rvalid), 32'(e_brv));
    if (e_ard_k) check("a_rdata", 32'(a_rdata), 32'(e_ard));
    if (e_brd_k) check("b_rdata", 32'(b_rdata), 32'(e_brd));
    if (a_req && rst_n && busy_left == 0 && !clr_start && !p_a) wa++; else wa = 0;
    if (b_req && rst_n && busy_left == 0 && !clr_start && !p_b) wb++; else wb = 0;
    check("fair_a", 32'(wa <= 2), 32'd1);
    check("fair_b", 32'(wb <= 2), 32'd1);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_req = 0; b_req = 0; clr_start = 0;
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic acc_a(input bit we, input int addr, input int data);
    bit ok = 0;
    a_req = 1; a_we = we; a_addr = AW'(addr); a_wdata = DW'(data);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (g_a) begin ok = 1; break; end
    end
    check("a_grant_bound", 32'(ok), 32'd1);
    a_req = 0;
  endtask

  task automatic acc_b(input bit we, input int addr, input int data);
    bit ok = 0;
    b_req = 1; b_we = we; b_addr = AW'(addr); b_wdata = DW'(data);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (g_b) begin ok = 1; break; end
    end
    check("b_grant_bound", 32'(ok), 32'd1);
    b_req = 0;
  endtask

  initial begin
    int nb;
    bit seen_done;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    clr_start = 0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    do_reset();
    check("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);

    // Write / read round trip through both requesters
    acc_a(1, 3, 8'h5A);
    acc_b(1, 7, 8'hC3);
    acc_a(0, 3, 0);
    acc_b(0, 7, 0);
    check("p1_a_rdata", 32'(a_rdata), 32'h5A);
    check("p1_b_rdata", 32'(b_rdata), 32'hC3);
    check("p1_acc_cnt", 32'(acc_cnt), 32'd4);

    // Continuous contention alternates starting with A
    do_reset();
    a_req = 1; a_we = 0; a_addr = 4'd1;
    b_req = 1; b_we = 0; b_addr = 4'd2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("p2_alt_a", 32'(g_a), 32'(i % 2 == 0));
    end
    a_req = 0; b_req = 0;
    check("p2_acc_cnt", 32'(acc_cnt), 32'd6);

    // Write then immediate read of the same address
    acc_a(1, 2, 8'h11);
    acc_a(0, 2, 0);
    check("p3_a_rdata", 32'(a_rdata), 32'h11);

    // Fill, clear with B pending and a second clr_start mid-sweep
    for (int i = 0; i < DEPTH; i++) acc_a(1, i, 8'hFF);
    b_req = 1; b_we = 0; b_addr = '0;
    clr_start = 1;
    cycle();
    check("p4_no_b_gnt", 32'(g_b), 32'd0);
    clr_start = 0;
    nb = 0; seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      clr_start = (i == 5);
      if (clr_done) seen_done = 1;
      cycle();
      if (g_busy) nb++;
      if (g_b) break;
    end
    clr_start = 0; b_req = 0;
    check("p4_busy_cycles", 32'(nb), 32'd16);
    check("p4_done_seen", 32'(seen_done), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      acc_b(0, i, 0);
      cycle();
      check("p4_cleared", 32'(b_rdata), 32'h00);
    end

    // Counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) acc_a(0, i % DEPTH, 0);
    check("p5_wrap0", 32'(acc_cnt), 32'h00);
    acc_b(0, 0, 0);
    check("p5_wrap1", 32'(acc_cnt), 32'h01);

    // Reset in the middle of a clear sweep
    for (int i = 0; i < DEPTH; i++) acc_a(1, i, 8'hFF);
    clr_start = 1;
    cycle();
    clr_start = 0;
    for (int i = 0; i < 5; i++) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("p6_busy_now", 32'(busy), 32'd0);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    acc_a(0, 0, 0);
    cycle();
    check("p6_rd0", 32'(a_rdata), 32'h00);
    acc_a(0, 10, 0);
    cycle();
    check("p6_rd10", 32'(a_rdata), 32'hFF);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (!a_req && $urandom_range(2) == 0) begin
        a_req = 1; a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
      end
      if (!b_req && $urandom_range(2) == 0) begin
        b_req = 1; b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
      end
      clr_start = ($urandom_range(49) == 0);
      cycle();
      if (g_a) a_req = 0;
      if (g_b) b_req = 0;
    end
    a_req = 0; b_req = 0; clr_start = 0;
    for (int i = 0; i < 20; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
